wd_window_monitor: RTL and testbench

//  Multi-channel windowed watchdog. An internal period counter replaces the external SWSTAT phase signal.

---
 rtl/wd_pkg.sv | 23 ++
 rtl/wd_window_monitor_if.sv | 36 +++
 rtl/wd_channel.sv | 107 ++++++++++
 rtl/wd_window_monitor.sv | 59 +++++
 tb/tb_wd_window_monitor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wd_pkg.sv
// Shared definitions for the windowed watchdog monitor.
//   FL_*   : per-period fault status codes reported on flstat
//   clog2  : ceiling log2, used to size the period and consecutive counters
// Optional feature macro used elsewhere in this slice: WD_FAULT_LOG_EN.
package wd_pkg;

  localparam logic [2:0] FL_OK    = 3'b000;
  localparam logic [2:0] FL_OVR   = 3'b001;
  localparam logic [2:0] FL_EARLY = 3'b010;
  localparam logic [2:0] FL_MULTI = 3'b011;
  localparam logic [2:0] FL_MISS  = 3'b100;

  // Returns at least 1 so a counter of a single state still has a bit.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wd_window_monitor_if.sv
// Bus bundle between the watchdog monitor and its environment.
//   en       : period counter run enable
//   wdsrvc   : per-channel service (rising edge = one service)
//   fwovr    : per-channel firmware override level
//   clrfail  : one-cycle clear of all wdfail flags and consecutive counters
//   winopen  : open-window indicator
//   perend   : last cycle of the period
//   flstat   : per-channel status of the last completed period, 3 bits each
//   wdfail   : sticky per-channel failure
//   flcnt    : per-channel bad-period count, present only with WD_FAULT_LOG_EN
// master = environment side, slave = monitor side.
interface wd_window_monitor_if #(parameter int N_CH = 4);

  logic              en;
  logic [N_CH-1:0]   wdsrvc;
  logic [N_CH-1:0]   fwovr;
  logic              clrfail;
  logic              winopen;
  logic              perend;
  logic [3*N_CH-1:0] flstat;
  logic [N_CH-1:0]   wdfail;
`ifdef WD_FAULT_LOG_EN
  logic [8*N_CH-1:0] flcnt;

  modport master (output en, wdsrvc, fwovr, clrfail,
                  input  winopen, perend, flstat, wdfail, flcnt);
  modport slave  (input  en, wdsrvc, fwovr, clrfail,
                  output winopen, perend, flstat, wdfail, flcnt);
`else
  modport master (output en, wdsrvc, fwovr, clrfail,
                  input  winopen, perend, flstat, wdfail);
  modport slave  (input  en, wdsrvc, fwovr, clrfail,
                  output winopen, perend, flstat, wdfail);
`endif

endinterface

// File: rtl/wd_channel.sv
// One watchdog channel: service edge detect, per-period accumulators,
// classifier, consecutive-bad counter, sticky wdfail and (with
// WD_FAULT_LOG_EN) a saturating bad-period log counter.
//   clk, rst_n : clock, async active-low reset
//   en         : period counter running; edges and override only count when 1
//   winopen    : shared open-window decode
//   pe         : period end that actually advances (perend & en)
//   srvc       : service input, ovr_in : override level, clrfail : fail clear
//   flstat     : registered status of the last period, wdfail : sticky failure
//   flcnt      : bad-period count (WD_FAULT_LOG_EN only)
module wd_channel
  import wd_pkg::*;
#(
  parameter int FAIL_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       winopen,
  input  logic       pe,
  input  logic       srvc,
  input  logic       ovr_in,
  input  logic       clrfail,
  output logic [2:0] flstat,
  output logic       wdfail
`ifdef WD_FAULT_LOG_EN
  ,
  output logic [7:0] flcnt
`endif
);

  localparam int CNT_W = clog2(FAIL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIL_LIMIT);

  logic             srvc_q;
  logic             early, early_n;
  logic             ovr, ovr_n;
  logic [1:0]       scnt, scnt_n;
  logic             edge_s;
  logic [2:0]       status;
  logic             bad;
  logic [CNT_W-1:0] consec, consec_inc;

  // The *_n values include the current cycle, so an edge or override on the
  // perend cycle is classified with the period that is ending.
  always_comb begin
    edge_s  = en & srvc & ~srvc_q;
    early_n = early | (edge_s & ~winopen);
    scnt_n  = scnt;
    if (edge_s && winopen && scnt != 2'd2) scnt_n = scnt + 2'd1;
    ovr_n   = ovr | (en & ovr_in);

    status = FL_OK;
    if (ovr_n)              status = FL_OVR;
    else if (early_n)       status = FL_EARLY;
    else if (scnt_n == 2'd2) status = FL_MULTI;
    else if (scnt_n == 2'd0) status = FL_MISS;

    bad        = (status == FL_EARLY) || (status == FL_MULTI) || (status == FL_MISS);
    consec_inc = (consec == LIMIT) ? consec : consec + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srvc_q <= 1'b0;
      early  <= 1'b0;
      scnt   <= 2'd0;
      ovr    <= 1'b0;
      flstat <= FL_OK;
    end else begin
      srvc_q <= srvc;
      if (pe) begin
        early  <= 1'b0;
        scnt   <= 2'd0;
        ovr    <= 1'b0;
        flstat <= status;
      end else begin
        early  <= early_n;
        scnt   <= scnt_n;
        ovr    <= ovr_n;
      end
    end
  end

  // An override period (FL_OVR) leaves the counter untouched. A set event
  // takes priority over a coincident clrfail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec <= '0;
      wdfail <= 1'b0;
    end else begin
      if (pe && bad)                            consec <= consec_inc;
      else if (clrfail || (pe && status == FL_OK)) consec <= '0;

      if (pe && bad && consec_inc == LIMIT) wdfail <= 1'b1;
      else if (clrfail)                     wdfail <= 1'b0;
    end
  end

`ifdef WD_FAULT_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           flcnt <= 8'd0;
    else if (pe && bad && flcnt != 8'hFF) flcnt <= flcnt + 8'd1;
  end
`endif

endmodule

// File: rtl/wd_window_monitor.sv
// Multi-channel windowed watchdog. A shared period counter splits each
// period into a closed window (0..WIN_OPEN-1) and an open window; each
// channel classifies its service pulses once per period and escalates
// consecutive bad periods to a sticky wdfail.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wd_window_monitor_if slave (en, wdsrvc, fwovr, clrfail in;
//           winopen, perend, flstat, wdfail and optional flcnt out)
// Optional feature: define WD_FAULT_LOG_EN to add the flcnt log counters.
module wd_window_monitor
  import wd_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PERIOD     = 100,
  parameter int WIN_OPEN   = 30,
  parameter int FAIL_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  wd_window_monitor_if.slave  bus
);

  localparam int CW = clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] OPEN = CW'(WIN_OPEN);

  logic [CW-1:0] cnt;
  logic          pe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (bus.en) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign bus.winopen = (cnt >= OPEN);
  assign bus.perend  = (cnt == LAST);
  // With en low the counter sits still, so a held perend must not close the period.
  assign pe          = bus.perend & bus.en;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wd_channel #(.FAIL_LIMIT(FAIL_LIMIT)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .winopen (bus.winopen),
      .pe      (pe),
      .srvc    (bus.wdsrvc[i]),
      .ovr_in  (bus.fwovr[i]),
      .clrfail (bus.clrfail),
      .flstat  (bus.flstat[3*i +: 3]),
      .wdfail  (bus.wdfail[i])
`ifdef WD_FAULT_LOG_EN
      ,
      .flcnt   (bus.flcnt[8*i +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_wd_window_monitor.sv
module tb_wd_window_monitor;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  int ea[4];
  int eb[4];
  int olo[4];
  int ohi[4];
  int clr_at;

  wd_window_monitor_if #(.N_CH(4)) bus ();

  wd_window_monitor #(.N_CH(4), .PERIOD(100), .WIN_OPEN(30), .FAIL_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_default();
    for (int ch = 0; ch < 4; ch++) begin
      ea[ch]  = 50;
      eb[ch]  = -1;
      olo[ch] = -1;
      ohi[ch] = -1;
    end
    clr_at = -1;
  endtask

  // Drives one full period starting at a negedge with counter 0; returns at
  // the negedge after the perend edge.
  task automatic run_period();
    logic [3:0] s, o;
    for (int c = 0; c < 100; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        s[ch] = (c == ea[ch]) || (c == eb[ch]);
        o[ch] = (c >= olo[ch]) && (c <= ohi[ch]);
      end
      bus.wdsrvc  = s;
      bus.fwovr   = o;
      bus.clrfail = (c == clr_at);
      @(negedge clk);
    end
    bus.wdsrvc  = 4'h0;
    bus.fwovr   = 4'h0;
    bus.clrfail = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.wdsrvc  = 4'h0;
    bus.fwovr   = 4'h0;
    bus.clrfail = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.flstat !== 12'h000) begin fails++; $display("FAIL reset_flstat got %h exp %h", bus.flstat, 12'h000); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL reset_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    tests++; if (bus.winopen !== 1'b0) begin fails++; $display("FAIL reset_winopen got %b exp 0", bus.winopen); end
    tests++; if (bus.perend !== 1'b0) begin fails++; $display("FAIL reset_perend got %b exp 0", bus.perend); end
`ifdef WD_FAULT_LOG_EN
    tests++; if (bus.flcnt !== 32'h0) begin fails++; $display("FAIL reset_flcnt got %h exp 0", bus.flcnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_ok();
    set_default();
    run_period();
    tests++; if (bus.flstat !== 12'h000) begin fails++; $display("FAIL ok_flstat got %h exp %h", bus.flstat, 12'h000); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL ok_wdfail got %h exp %h", bus.wdfail, 4'h0); end
  endtask

  task automatic test_early();
    set_default();
    ea[1] = 10;
    run_period();
    tests++; if (bus.flstat !== 12'h010) begin fails++; $display("FAIL early_flstat got %h exp %h", bus.flstat, 12'h010); end
    set_default();
    ea[1] = 10; eb[1] = 50; ea[2] = 10;
    run_period();
    tests++; if (bus.flstat !== 12'h090) begin fails++; $display("FAIL early_multi_flstat got %h exp %h", bus.flstat, 12'h090); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL early_wdfail got %h exp %h", bus.wdfail, 4'h0); end
  endtask

  task automatic test_override_escalate();
    set_default();
    ea[2] = -1; olo[2] = 50; ohi[2] = 59;
    ea[3] = 40; eb[3] = 60;
    run_period();
    tests++; if (bus.flstat !== 12'h640) begin fails++; $display("FAIL ovr_flstat got %h exp %h", bus.flstat, 12'h640); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL ovr_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    set_default();
    ea[2] = 10; ea[3] = 40; eb[3] = 60;
    run_period();
    tests++; if (bus.flstat !== 12'h680) begin fails++; $display("FAIL esc2_flstat got %h exp %h", bus.flstat, 12'h680); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL esc2_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    set_default();
    ea[2] = 10; ea[3] = 40; eb[3] = 60;
    run_period();
    tests++; if (bus.flstat !== 12'h680) begin fails++; $display("FAIL esc3_flstat got %h exp %h", bus.flstat, 12'h680); end
    tests++; if (bus.wdfail !== 4'hC) begin fails++; $display("FAIL esc3_wdfail got %h exp %h", bus.wdfail, 4'hC); end
  endtask

  task automatic test_clrfail();
    set_default();
    clr_at = 5;
    ea[2] = 99;
    run_period();
    tests++; if (bus.flstat !== 12'h000) begin fails++; $display("FAIL clr_perend_edge_flstat got %h exp %h", bus.flstat, 12'h000); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL clr_wdfail got %h exp %h", bus.wdfail, 4'h0); end
  endtask

  task automatic test_clr_collide();
    set_default(); ea[3] = 40; eb[3] = 60;
    run_period();
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL col1_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    run_period();
    tests++; if (bus.flstat !== 12'h600) begin fails++; $display("FAIL col2_flstat got %h exp %h", bus.flstat, 12'h600); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL col2_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    clr_at = 99;
    run_period();
    tests++; if (bus.wdfail !== 4'h8) begin fails++; $display("FAIL col3_set_wins got %h exp %h", bus.wdfail, 4'h8); end
    set_default(); clr_at = 5;
    run_period();
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL col_clear got %h exp %h", bus.wdfail, 4'h0); end
    tests++; if (bus.flstat !== 12'h000) begin fails++; $display("FAIL col_clear_flstat got %h exp %h", bus.flstat, 12'h000); end
  endtask

  task automatic test_miss();
    set_default(); ea[0] = -1;
    run_period();
    tests++; if (bus.flstat !== 12'h004) begin fails++; $display("FAIL miss1_flstat got %h exp %h", bus.flstat, 12'h004); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL miss1_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    run_period();
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL miss2_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    run_period();
    tests++; if (bus.flstat !== 12'h004) begin fails++; $display("FAIL miss3_flstat got %h exp %h", bus.flstat, 12'h004); end
    tests++; if (bus.wdfail !== 4'h1) begin fails++; $display("FAIL miss3_wdfail got %h exp %h", bus.wdfail, 4'h1); end
`ifdef WD_FAULT_LOG_EN
    tests++; if (bus.flcnt !== 32'h06030203) begin fails++; $display("FAIL flcnt got %h exp %h", bus.flcnt, 32'h06030203); end
`endif
  endtask

  task automatic test_reset_mid();
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (bus.flstat !== 12'h000) begin fails++; $display("FAIL rstmid_flstat got %h exp %h", bus.flstat, 12'h000); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL rstmid_wdfail got %h exp %h", bus.wdfail, 4'h0); end
    tests++; if (bus.winopen !== 1'b0) begin fails++; $display("FAIL rstmid_winopen got %b exp 0", bus.winopen); end
`ifdef WD_FAULT_LOG_EN
    tests++; if (bus.flcnt !== 32'h0) begin fails++; $display("FAIL rstmid_flcnt got %h exp 0", bus.flcnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    for (int c = 0; c < 100; c++) begin
      bus.wdsrvc = (c == 50) ? 4'hF : 4'h0;
      if (c == 29) begin tests++; if (bus.winopen !== 1'b0) begin fails++; $display("FAIL winopen_29 got %b exp 0", bus.winopen); end end
      if (c == 30) begin tests++; if (bus.winopen !== 1'b1) begin fails++; $display("FAIL winopen_30 got %b exp 1", bus.winopen); end end
      if (c == 98) begin tests++; if (bus.perend !== 1'b0) begin fails++; $display("FAIL perend_98 got %b exp 0", bus.perend); end end
      if (c == 99) begin tests++; if (bus.perend !== 1'b1) begin fails++; $display("FAIL perend_99 got %b exp 1", bus.perend); end end
      @(negedge clk);
    end
    bus.wdsrvc = 4'h0;
    tests++; if (bus.flstat !== 12'h000) begin fails++; $display("FAIL decode_flstat got %h exp %h", bus.flstat, 12'h000); end
  endtask

  task automatic test_freeze();
    for (int k = 0; k < 120; k++) begin
      bus.en = !(k >= 20 && k < 40);
      bus.wdsrvc = 4'h0;
      if (k == 25) bus.wdsrvc = 4'h2;
      if (k == 70) bus.wdsrvc = 4'hD;
      if (k == 49) begin tests++; if (bus.winopen !== 1'b0) begin fails++; $display("FAIL frz_winopen_49 got %b exp 0", bus.winopen); end end
      if (k == 50) begin tests++; if (bus.winopen !== 1'b1) begin fails++; $display("FAIL frz_winopen_50 got %b exp 1", bus.winopen); end end
      if (k == 99) begin tests++; if (bus.perend !== 1'b0) begin fails++; $display("FAIL frz_perend_99 got %b exp 0", bus.perend); end end
      if (k == 119) begin tests++; if (bus.perend !== 1'b1) begin fails++; $display("FAIL frz_perend_119 got %b exp 1", bus.perend); end end
      @(negedge clk);
    end
    bus.wdsrvc = 4'h0;
    bus.en     = 1'b1;
    tests++; if (bus.flstat !== 12'h020) begin fails++; $display("FAIL frz_flstat got %h exp %h", bus.flstat, 12'h020); end
    tests++; if (bus.wdfail !== 4'h0) begin fails++; $display("FAIL frz_wdfail got %h exp %h", bus.wdfail, 4'h0); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ok();
    test_early();
    test_override_escalate();
    test_clrfail();
    test_clr_collide();
    test_miss();
    test_reset_mid();
    test_decode();
    test_freeze();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
